vga_rx_monitor: RTL and testbench
=================================

Name: vga_rx_monitor

Overview:
- Sink-side companion to the SoC VGA output peripheral. It consumes the VGA pixel/sync stream in the same clock domain and measures the frame timing: active width/height, total clocks per line, lines per frame.
- It also accumulates a per-frame pixel checksum and counts frames.
- Results are exposed through an APB responder so software and testbenches can check the display pipeline in-system.

Parameters:
- CNT_W, 12, width of all timing counters; counters saturate at 2^CNT_W-1.
- SYNC_ACTIVE_LOW, 1, 1: sync pulses are low (sync edge = falling); 0: sync edge = rising.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- vga_r  input  8  red
- vga_g  input  8  green
- vga_b  input  8  blue
- vga_hsync  input  1  horizontal sync
- vga_vsync  input  1  vertical sync
- vga_valid  input  1  active-pixel qualifier
- in_paddr  input  32  APB address; only [4:2] decoded
- in_psel  input  1  APB select
- in_penable  input  1  APB enable
- in_pprot  input  3  ignored
- in_pwrite  input  1  APB write
- in_pwdata  input  32  APB write data
- in_pstrb  input  4  byte strobes
- in_pready  output  1  APB ready
- in_prdata  output  32  APB read data
- in_pslverr  output  1  APB error

Behaviour:
- Clocking and reset: clock drives everything. Reset is synchronous, active-high.
- Reset values: all registers 0; in_pready=0, in_prdata=0, in_pslverr=0.
- Register map (byte offsets):
  - 0x00 CTRL rw: [0] EN; [1] CLR, self-clearing, zeroes FRAMES; [2] IRQ_EN.
  - 0x04 STATUS: [0] LOCKED ro; [1] FRAME_DONE sticky, write-1-to-clear.
  - 0x08 HRES ro: [11:0] active width; [27:16] htotal.
  - 0x0C VRES ro: [11:0] active height; [27:16] vtotal.
  - 0x10 FRAMES ro: latched-frame count, wraps at 2^32.
  - 0x14 CSUM ro: sum of {8'h0,r,g,b} over valid pixels, mod 2^32.
- APB:
  - Zero wait states: in_pready = psel & penable. in_prdata is valid in the same access cycle; in_prdata is 0 outside reads.
  - Offsets >= 0x18: in_pslverr=1 during access, read data 0, write ignored.
  - Writes commit on the edge with psel&penable&pwrite. CTRL honours pstrb[0] only; writes to read-only registers are ignored.
- Edge detect:
  - Previous sync levels are registered; a sync edge is the active transition between the previous sample and the current one.
  - This gives one cycle of detection latency, identical for hsync and vsync.
- Line counters:
  - On hsync edge: clk_cnt <= 1; otherwise clk_cnt++ (saturating).
  - At each hsync edge, the previous clk_cnt+1 is stored as line_total. pix_cnt (valid pixels in the line) is stored as line_width if nonzero, then cleared.
- Frame counters:
  - On vsync edge: line_cnt <= 1, which counts the coincident hsync if present; every other hsync edge does line_cnt++.
  - act_lines increments at each hsync edge that closes a line with pix_cnt>0.
  - csum accumulates every cycle with vga_valid=1, regardless of sync level.
- Frame latch at a vsync edge, only when armed:
  - HRES <= {line_total, line_width}; VRES <= {line_cnt, act_lines}; CSUM <= csum; FRAMES++; FRAME_DONE <= 1.
  - Then accumulators clear.
  - Values are readable the cycle after the edge sample.
- Simultaneous hsync+vsync edge: the line closes first, and its totals are included in the frame latched on that same cycle.
- Arming:
  - EN 0->1 clears accumulators and disarms.
  - The first vsync edge arms the block; the partial frame is discarded and not latched.
  - EN=0 freezes latched registers and clears accumulators.
- LOCKED: set when a latched frame's HRES and VRES equal the previous latched frame's values. Cleared on any mismatch, on EN=0, or on reset.
- CLR and a frame latch in the same cycle: CLR wins, so FRAMES=0.
- Reset mid-frame: everything returns to reset values and the block requires re-enable.

Optional Feature:
- VGA_RX_MONITOR_IRQ_EN
  - Defined: adds output port irq (1 bit, reset 0), registered, irq = FRAME_DONE & IRQ_EN.
  - Undefined: no irq port; CTRL[2] reads 0 and is not writable.

Decomposition:
- Shared package vga_rx_pkg holds:
  - register offset constants (CTRL..CSUM);
  - CTRL/STATUS bit-index constants;
  - a packed struct for latched timing {htotal, hwidth, vtotal, vheight}.
- One natural sub-module: vga_rx_timing. It covers edge detect, counters and the frame latch, and outputs the timing struct, csum and a frame_strobe. The top level holds the APB register file.

Test Plan:
- Reset, then read 0x00..0x14: all read 0, in_pready=1 in each access cycle, in_pslverr=0.
- Drive the 800x525 VGA source (hsync low clocks 1-96, vsync low lines 1-2, valid x 145-784 / y 36-515, pixel 0x123456), set EN=1, wait 3 vsync edges:
  - HRES=0x0320_0280, VRES=0x020D_01E0, CSUM=0x5553_2000, FRAMES=2, LOCKED=1.
- Change h_total to 801 for one frame after lock: next latch gives htotal=801 and LOCKED=0; the following frame at 800 gives LOCKED=0, and the next gives LOCKED=1.
- Write STATUS=0x2: FRAME_DONE clears. Write CTRL=0x3: FRAMES reads 0 and CTRL[1] reads back 0 next cycle.
- Drop EN mid-frame, then re-enable: the first partial frame is not latched, FRAMES increments only on the second vsync edge.
- Access paddr=0x18 (read and write): in_pslverr=1, in_prdata=0, no register changes.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// Shared definitions for the VGA receive monitor: APB register offsets,
// CTRL/STATUS bit positions and the latched frame-timing record.
package vga_rx_pkg;

  // Width of each field in the latched timing record (register fields are 12 bits).
  localparam int TIM_W = 12;

  // Register byte offsets.
  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_HRES   = 5'h08;
  localparam logic [4:0] OFF_VRES   = 5'h0C;
  localparam logic [4:0] OFF_FRAMES = 5'h10;
  localparam logic [4:0] OFF_CSUM   = 5'h14;

  // CTRL bits.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits.
  localparam int STAT_LOCKED     = 0;
  localparam int STAT_FRAME_DONE = 1;

  // Timing captured at each frame latch.
  typedef struct packed {
    logic [TIM_W-1:0] htotal;
    logic [TIM_W-1:0] hwidth;
    logic [TIM_W-1:0] vtotal;
    logic [TIM_W-1:0] vheight;
  } timing_t;

endpackage

// File: rtl/vga_rx_timing.sv
// Sync edge detection, line/frame counters, pixel checksum and the frame latch.
// Produces the latched timing record, latched checksum, LOCKED and a
// one-cycle frame_strobe for every latched frame.
module vga_rx_timing
  import vga_rx_pkg::*;
#(
  parameter int CNT_W           = 12,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [23:0] pixel,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  output timing_t     timing,
  output logic [31:0] csum,
  output logic        frame_strobe,
  output logic        locked
);

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic        armed_q, armed_d, locked_q, locked_d;
  cnt_t        clk_cnt_q, clk_cnt_d, pix_cnt_q, pix_cnt_d;
  cnt_t        line_cnt_q, line_cnt_d, act_lines_q, act_lines_d;
  cnt_t        line_total_q, line_total_d, line_width_q, line_width_d;
  logic [31:0] csum_acc_q, csum_acc_d, csum_q, csum_d;
  timing_t     timing_q, timing_d;

  logic        hs_edge, vs_edge, line_has_pix;
  cnt_t        close_total, close_width, close_act;
  logic [31:0] pix_word;
  timing_t     new_timing;

  assign hs_edge = SYNC_ACTIVE_LOW ? (hs_prev_q & ~hsync) : (~hs_prev_q & hsync);
  assign vs_edge = SYNC_ACTIVE_LOW ? (vs_prev_q & ~vsync) : (~vs_prev_q & vsync);

  // Values as they stand once the line ending this cycle (if any) is closed,
  // so a coincident vsync edge latches a frame that includes that line.
  assign line_has_pix = hs_edge && (pix_cnt_q != '0);
  assign close_total  = hs_edge ? clk_cnt_q : line_total_q;
  assign close_width  = line_has_pix ? pix_cnt_q : line_width_q;
  assign close_act    = line_has_pix ? sat_inc(act_lines_q) : act_lines_q;
  assign pix_word     = valid ? {8'h00, pixel} : 32'h0;

  assign new_timing = '{htotal:  TIM_W'(close_total),
                        hwidth:  TIM_W'(close_width),
                        vtotal:  TIM_W'(line_cnt_q),
                        vheight: TIM_W'(close_act)};

  // Counter advance, line close and frame latch.
  always_comb begin
    hs_prev_d    = hsync;
    vs_prev_d    = vsync;
    armed_d      = armed_q;
    locked_d     = locked_q;
    clk_cnt_d    = clk_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    act_lines_d  = act_lines_q;
    line_total_d = line_total_q;
    line_width_d = line_width_q;
    csum_acc_d   = csum_acc_q;
    csum_d       = csum_q;
    timing_d     = timing_q;
    frame_strobe = 1'b0;
    if (!en) begin
      // Disabled: latched results frozen, accumulators idle, must re-arm.
      armed_d      = 1'b0;
      locked_d     = 1'b0;
      clk_cnt_d    = '0;
      pix_cnt_d    = '0;
      line_cnt_d   = '0;
      act_lines_d  = '0;
      line_total_d = '0;
      line_width_d = '0;
      csum_acc_d   = '0;
    end else begin
      clk_cnt_d    = hs_edge ? cnt_t'(1) : sat_inc(clk_cnt_q);
      if (hs_edge)    pix_cnt_d = valid ? cnt_t'(1) : '0;
      else if (valid) pix_cnt_d = sat_inc(pix_cnt_q);
      line_cnt_d   = hs_edge ? sat_inc(line_cnt_q) : line_cnt_q;
      act_lines_d  = close_act;
      line_total_d = close_total;
      line_width_d = close_width;
      csum_acc_d   = csum_acc_q + pix_word;
      if (vs_edge) begin
        // First edge after enable only arms; the partial frame is dropped.
        if (armed_q) begin
          timing_d     = new_timing;
          csum_d       = csum_acc_q;
          locked_d     = (new_timing == timing_q);
          frame_strobe = 1'b1;
        end
        armed_d      = 1'b1;
        line_cnt_d   = cnt_t'(1);
        act_lines_d  = '0;
        line_total_d = '0;
        line_width_d = '0;
        csum_acc_d   = pix_word;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      armed_q      <= 1'b0;
      locked_q     <= 1'b0;
      clk_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      act_lines_q  <= '0;
      line_total_q <= '0;
      line_width_q <= '0;
      csum_acc_q   <= '0;
      csum_q       <= '0;
      timing_q     <= '0;
    end else begin
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      armed_q      <= armed_d;
      locked_q     <= locked_d;
      clk_cnt_q    <= clk_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      act_lines_q  <= act_lines_d;
      line_total_q <= line_total_d;
      line_width_q <= line_width_d;
      csum_acc_q   <= csum_acc_d;
      csum_q       <= csum_d;
      timing_q     <= timing_d;
    end
  end

  assign timing = timing_q;
  assign csum   = csum_q;
  assign locked = locked_q;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor top: APB register file around vga_rx_timing.
// Optional interrupt output enabled by defining VGA_RX_MONITOR_IRQ_EN.
module vga_rx_monitor
  import vga_rx_pkg::*;
#(
  parameter int CNT_W           = 12,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_valid,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr
`ifdef VGA_RX_MONITOR_IRQ_EN
  ,
  output logic        irq
`endif
);

  timing_t     timing;
  logic [31:0] csum;
  logic        frame_strobe, locked;

  logic        en_q, en_d, frame_done_q, frame_done_d, frame_done_clr;
  logic [31:0] frames_q, frames_d;
`ifdef VGA_RX_MONITOR_IRQ_EN
  logic        irq_en_q, irq_en_d, irq_q, irq_d;
`endif

  logic        access, wr, rd, bad;
  logic [4:0]  off;
  logic        unused_apb;

  assign access = in_psel & in_penable;
  assign wr     = access & in_pwrite;
  assign rd     = access & ~in_pwrite;
  assign off    = {in_paddr[4:2], 2'b00};
  assign bad    = (in_paddr[4:3] == 2'b11);

  assign in_pready  = access;
  assign in_pslverr = access & bad;
  assign unused_apb = ^{in_pprot, in_paddr[31:5], in_paddr[1:0], in_pstrb[3:1], in_pwdata[31:2]};

  vga_rx_timing #(
    .CNT_W           (CNT_W),
    .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_timing (
    .clock        (clock),
    .reset        (reset),
    .en           (en_q),
    .pixel        ({vga_r, vga_g, vga_b}),
    .hsync        (vga_hsync),
    .vsync        (vga_vsync),
    .valid        (vga_valid),
    .timing       (timing),
    .csum         (csum),
    .frame_strobe (frame_strobe),
    .locked       (locked)
  );

  // Register writes; CLR acts on the write itself so it beats a same-cycle latch.
  always_comb begin
    en_d           = en_q;
    frames_d       = frame_strobe ? frames_q + 32'd1 : frames_q;
    frame_done_clr = 1'b0;
`ifdef VGA_RX_MONITOR_IRQ_EN
    irq_en_d       = irq_en_q;
`endif
    if (wr && !bad && in_pstrb[0]) begin
      case (off)
        OFF_CTRL: begin
          en_d = in_pwdata[CTRL_EN];
          if (in_pwdata[CTRL_CLR]) frames_d = '0;
`ifdef VGA_RX_MONITOR_IRQ_EN
          irq_en_d = in_pwdata[CTRL_IRQ_EN];
`endif
        end
        OFF_STATUS: frame_done_clr = in_pwdata[STAT_FRAME_DONE];
        default: ;
      endcase
    end
    frame_done_d = frame_strobe | (frame_done_q & ~frame_done_clr);
`ifdef VGA_RX_MONITOR_IRQ_EN
    irq_d = frame_done_q & irq_en_q;
`endif
  end

  // Read mux; data is zero outside valid read accesses.
  always_comb begin
    in_prdata = '0;
    if (rd && !bad) begin
      case (off)
        OFF_CTRL: begin
          in_prdata[CTRL_EN] = en_q;
`ifdef VGA_RX_MONITOR_IRQ_EN
          in_prdata[CTRL_IRQ_EN] = irq_en_q;
`endif
        end
        OFF_STATUS: begin
          in_prdata[STAT_LOCKED]     = locked;
          in_prdata[STAT_FRAME_DONE] = frame_done_q;
        end
        OFF_HRES:   in_prdata = {4'h0, timing.htotal, 4'h0, timing.hwidth};
        OFF_VRES:   in_prdata = {4'h0, timing.vtotal, 4'h0, timing.vheight};
        OFF_FRAMES: in_prdata = frames_q;
        OFF_CSUM:   in_prdata = csum;
        default: ;
      endcase
    end
  end

  // Register file state.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q         <= 1'b0;
      frame_done_q <= 1'b0;
      frames_q     <= '0;
`ifdef VGA_RX_MONITOR_IRQ_EN
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
`endif
    end else begin
      en_q         <= en_d;
      frame_done_q <= frame_done_d;
      frames_q     <= frames_d;
`ifdef VGA_RX_MONITOR_IRQ_EN
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
`endif
    end
  end

`ifdef VGA_RX_MONITOR_IRQ_EN
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor. A scaled VGA source (40 clocks x 20
// lines, hsync low clocks 1-6, vsync low lines 1-2, valid x 9-32 / y 4-15,
// pixel 0x123456) keeps each frame at 800 clocks.
module tb_vga_rx_monitor;

  localparam int V_TOT = 20, H_SYNC = 6, V_SYNC = 2;
  localparam int X0 = 9, X1 = 32, Y0 = 4, Y1 = 15;
  localparam logic [23:0] PIX = 24'h123456;
  // 24 x 12 = 288 pixels: 288 * 0x123456 = 0x147AE0C0
  localparam logic [31:0] E_HRES = 32'h0028_0018, E_HRES41 = 32'h0029_0018;
  localparam logic [31:0] E_VRES = 32'h0014_000C, E_CSUM = 32'h147A_E0C0;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_valid;
  logic [31:0] in_paddr, in_pwdata, in_prdata;
  logic        in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
  logic [2:0]  in_pprot;
  logic [3:0]  in_pstrb;
`ifdef VGA_RX_MONITOR_IRQ_EN
  logic        irq;
`endif

  int n_chk = 0, n_pass = 0;
  int vs_cnt = 0;
  int h_total_cfg = 40;

  always #5 clock = ~clock;

  vga_rx_monitor dut (
    .clock(clock), .reset(reset),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_valid(vga_valid),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
    .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
    .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
    .in_pslverr(in_pslverr)
`ifdef VGA_RX_MONITOR_IRQ_EN
    , .irq(irq)
`endif
  );

  // Free-running video source; h_total_cfg is sampled at each frame start.
  initial begin
    vga_r = 0; vga_g = 0; vga_b = 0;
    vga_hsync = 1; vga_vsync = 1; vga_valid = 0;
    @(posedge clock);
    forever begin
      int ht;
      ht = h_total_cfg;
      for (int y = 1; y <= V_TOT; y++)
        for (int x = 1; x <= ht; x++) begin
          #1;
          vga_hsync = !(x <= H_SYNC);
          vga_vsync = !(y <= V_SYNC);
          vga_valid = (x >= X0 && x <= X1 && y >= Y0 && y <= Y1);
          {vga_r, vga_g, vga_b} = vga_valid ? PIX : 24'h0;
          if (x == 1 && y == 1) vs_cnt++;
          @(posedge clock);
        end
    end
  end

  task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rdat, output logic rdy, output logic err);
    @(posedge clock); #1;
    in_psel = 1; in_penable = 0; in_paddr = a; in_pwrite = w; in_pwdata = d; in_pstrb = 4'hF;
    @(posedge clock); #1;
    in_penable = 1;
    @(negedge clock);
    rdat = in_prdata; rdy = in_pready; err = in_pslverr;
    @(posedge clock); #1;
    in_psel = 0; in_penable = 0; in_pwrite = 0;
  endtask

  task automatic wait_vs(input int n);
    int tgt, cyc;
    tgt = vs_cnt + n; cyc = 0;
    while (vs_cnt < tgt && cyc < 1000 * n) begin @(posedge clock); cyc++; end
    if (vs_cnt < tgt) begin
      n_chk++;
      $display("FAIL vsync_wait: got %0d frame starts, expected %0d", vs_cnt, tgt);
    end
    repeat (4) @(posedge clock);
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic rdy, err;
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_chk++; if (in_pready !== 1'b0) $display("FAIL rst_pready: got %b exp 0", in_pready); else n_pass++;
    n_chk++; if (in_prdata !== 32'h0) $display("FAIL rst_prdata: got %h exp 0", in_prdata); else n_pass++;
    n_chk++; if (in_pslverr !== 1'b0) $display("FAIL rst_pslverr: got %b exp 0", in_pslverr); else n_pass++;
    @(posedge clock); #1; reset = 0;
    for (int i = 0; i < 6; i++) begin
      apb(32'(i * 4), 1'b0, 32'h0, rd, rdy, err);
      n_chk++; if (rd !== 32'h0) $display("FAIL rst_reg_%0h: got %h exp 0", i * 4, rd); else n_pass++;
      n_chk++; if (rdy !== 1'b1) $display("FAIL rst_rdy_%0h: got %b exp 1", i * 4, rdy); else n_pass++;
      n_chk++; if (err !== 1'b0) $display("FAIL rst_err_%0h: got %b exp 0", i * 4, err); else n_pass++;
    end
  endtask

  task automatic test_lock();
    logic [31:0] rd; logic rdy, err;
    wait_vs(1);
    apb(32'h00, 1'b1, 32'h1, rd, rdy, err);
    wait_vs(3);
    apb(32'h08, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== E_HRES) $display("FAIL lock_hres: got %h exp %h", rd, E_HRES); else n_pass++;
    apb(32'h0C, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== E_VRES) $display("FAIL lock_vres: got %h exp %h", rd, E_VRES); else n_pass++;
    apb(32'h14, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== E_CSUM) $display("FAIL lock_csum: got %h exp %h", rd, E_CSUM); else n_pass++;
    apb(32'h10, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'd2) $display("FAIL lock_frames: got %0d exp 2", rd); else n_pass++;
    apb(32'h04, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h3) $display("FAIL lock_status: got %h exp 3", rd); else n_pass++;
  endtask

  task automatic test_mismatch();
    logic [31:0] rd; logic rdy, err;
    h_total_cfg = 41;
    wait_vs(1);
    h_total_cfg = 40;
    wait_vs(1);
    apb(32'h08, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== E_HRES41) $display("FAIL mis_hres41: got %h exp %h", rd, E_HRES41); else n_pass++;
    apb(32'h04, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h2) $display("FAIL mis_status41: got %h exp 2", rd); else n_pass++;
    wait_vs(1);
    apb(32'h08, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== E_HRES) $display("FAIL mis_hres40: got %h exp %h", rd, E_HRES); else n_pass++;
    apb(32'h04, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h2) $display("FAIL mis_status40: got %h exp 2", rd); else n_pass++;
    wait_vs(1);
    apb(32'h04, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h3) $display("FAIL mis_relock: got %h exp 3", rd); else n_pass++;
    apb(32'h10, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'd6) $display("FAIL mis_frames: got %0d exp 6", rd); else n_pass++;
  endtask

  task automatic test_status_clr();
    logic [31:0] rd; logic rdy, err;
    apb(32'h04, 1'b1, 32'h2, rd, rdy, err);
    apb(32'h04, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h1) $display("FAIL w1c_status: got %h exp 1", rd); else n_pass++;
    apb(32'h00, 1'b1, 32'h3, rd, rdy, err);
    apb(32'h10, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h0) $display("FAIL clr_frames: got %0d exp 0", rd); else n_pass++;
    apb(32'h00, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h1) $display("FAIL clr_ctrl: got %h exp 1", rd); else n_pass++;
    apb(32'h00, 1'b1, 32'h5, rd, rdy, err);
    apb(32'h00, 1'b0, 0, rd, rdy, err);
`ifdef VGA_RX_MONITOR_IRQ_EN
    n_chk++; if (rd !== 32'h5) $display("FAIL irq_en_ctrl: got %h exp 5", rd); else n_pass++;
    n_chk++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b exp 0", irq); else n_pass++;
`else
    n_chk++; if (rd !== 32'h1) $display("FAIL irq_en_ctrl: got %h exp 1", rd); else n_pass++;
`endif
    apb(32'h00, 1'b1, 32'h1, rd, rdy, err);
    wait_vs(1);
    apb(32'h10, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'd1) $display("FAIL post_clr_frames: got %0d exp 1", rd); else n_pass++;
    apb(32'h04, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h3) $display("FAIL post_clr_status: got %h exp 3", rd); else n_pass++;
  endtask

  task automatic test_en_drop();
    logic [31:0] rd; logic rdy, err;
    repeat (200) @(posedge clock);
    apb(32'h00, 1'b1, 32'h0, rd, rdy, err);
    apb(32'h04, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h2) $display("FAIL dis_status: got %h exp 2", rd); else n_pass++;
    wait_vs(1);
    apb(32'h10, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'd1) $display("FAIL dis_frames: got %0d exp 1", rd); else n_pass++;
    apb(32'h08, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== E_HRES) $display("FAIL dis_hres: got %h exp %h", rd, E_HRES); else n_pass++;
    repeat (200) @(posedge clock);
    apb(32'h00, 1'b1, 32'h1, rd, rdy, err);
    wait_vs(1);
    apb(32'h10, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'd1) $display("FAIL rearm_frames: got %0d exp 1", rd); else n_pass++;
    wait_vs(1);
    apb(32'h10, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'd2) $display("FAIL reen_frames: got %0d exp 2", rd); else n_pass++;
    apb(32'h14, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== E_CSUM) $display("FAIL reen_csum: got %h exp %h", rd, E_CSUM); else n_pass++;
  endtask

  task automatic test_slverr();
    logic [31:0] rd; logic rdy, err;
    apb(32'h18, 1'b0, 0, rd, rdy, err);
    n_chk++; if (err !== 1'b1) $display("FAIL bad_rd_err: got %b exp 1", err); else n_pass++;
    n_chk++; if (rd !== 32'h0) $display("FAIL bad_rd_data: got %h exp 0", rd); else n_pass++;
    n_chk++; if (rdy !== 1'b1) $display("FAIL bad_rd_rdy: got %b exp 1", rdy); else n_pass++;
    apb(32'h18, 1'b1, 32'hFFFF_FFFF, rd, rdy, err);
    n_chk++; if (err !== 1'b1) $display("FAIL bad_wr_err: got %b exp 1", err); else n_pass++;
    apb(32'h1C, 1'b0, 0, rd, rdy, err);
    n_chk++; if (err !== 1'b1) $display("FAIL bad_1c_err: got %b exp 1", err); else n_pass++;
    apb(32'h00, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'h1) $display("FAIL bad_ctrl_kept: got %h exp 1", rd); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL good_err: got %b exp 0", err); else n_pass++;
    apb(32'h10, 1'b0, 0, rd, rdy, err);
    n_chk++; if (rd !== 32'd2) $display("FAIL bad_frames_kept: got %0d exp 2", rd); else n_pass++;
  endtask

  initial begin
    in_psel = 0; in_penable = 0; in_pwrite = 0; in_paddr = 0;
    in_pwdata = 0; in_pstrb = 0; in_pprot = 0;
    test_reset();
    test_lock();
    test_mismatch();
    test_status_clr();
    test_en_drop();
    test_slverr();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
